// File: rtl/reg_debug_port.sv
// Debug port that halts the CPU and reads or writes its register file on command.
// Optional macro REG_DUMP_EN adds op 10: a full 32-register dump.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module reg_debug_port #(
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [4:0]             cmd_addr,
  input  logic [`DATA_WIDTH-1:0] cmd_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [`DATA_WIDTH-1:0] rsp_data,
  output logic [4:0]             rsp_addr,
  output logic                   rsp_last,
  output logic                   rsp_err,
  output logic                   halt_req,
  input  logic                   halt_ack,
  output logic [4:0]             rf_raddr,
  input  logic [`DATA_WIDTH-1:0] rf_rdata,
  output logic [4:0]             rf_waddr,
  output logic [`DATA_WIDTH-1:0] rf_wdata,
  output logic                   rf_wen,
  output logic [1:0]             dbg_state
);
  localparam int DW = `DATA_WIDTH;
  localparam int TW = (HALT_TIMEOUT < 2) ? 1 : $clog2(HALT_TIMEOUT + 1);
  localparam logic [1:0] OP_RD = 2'b00;
  localparam logic [1:0] OP_WR = 2'b01;
`ifdef REG_DUMP_EN
  localparam logic [1:0] OP_DUMP = 2'b10;
`endif

  typedef enum logic [1:0] {IDLE, REQ, EXEC, RESP} state_t;
  state_t          state;
  logic [1:0]      op;
  logic [4:0]      addr;
  logic [DW-1:0]   wdata;
  logic [TW-1:0]   tcnt;
  logic            ack_seen;
  logic            wen_q;
  logic            op_supported;

  always_comb begin
    op_supported = (cmd_op == OP_RD) || (cmd_op == OP_WR);
`ifdef REG_DUMP_EN
    if (cmd_op == OP_DUMP) op_supported = 1'b1;
`endif
  end

  assign cmd_ready = (state == IDLE);
  assign dbg_state = state;
  // The write strobe is also gated by the live halt_ack so a CPU that resumes never sees a write.
  assign rf_wen = wen_q && halt_ack && (state == EXEC);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state     <= IDLE;
      op        <= OP_RD;
      addr      <= '0;
      wdata     <= '0;
      tcnt      <= '0;
      ack_seen  <= 1'b0;
      wen_q     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_addr  <= '0;
      rsp_last  <= 1'b0;
      rsp_err   <= 1'b0;
      halt_req  <= 1'b0;
      rf_raddr  <= '0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
    end else begin
      case (state)
        IDLE: if (cmd_valid) begin
          op       <= cmd_op;
          wdata    <= cmd_wdata;
          addr     <= cmd_addr;
          tcnt     <= '0;
          ack_seen <= 1'b0;
          if (op_supported) begin
            state    <= REQ;
            halt_req <= 1'b1;
`ifdef REG_DUMP_EN
            if (cmd_op == OP_DUMP) addr <= '0;
`endif
          end else begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            rsp_addr  <= cmd_addr;
            rsp_err   <= 1'b1;
            rsp_last  <= 1'b1;
          end
        end
        REQ: begin
          if (halt_ack) begin
            // halt_ack must be seen on one edge before EXEC is entered on the next.
            if (ack_seen) begin
              state    <= EXEC;
              rf_raddr <= addr;
              rf_waddr <= addr;
              rf_wdata <= wdata;
              wen_q    <= (op == OP_WR) && (addr != 5'd0);
            end else begin
              ack_seen <= 1'b1;
            end
          end else begin
            ack_seen <= 1'b0;
            if (tcnt == TW'(HALT_TIMEOUT - 1)) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_data  <= '0;
              rsp_addr  <= addr;
              rsp_err   <= 1'b1;
              rsp_last  <= 1'b1;
            end else begin
              tcnt <= tcnt + TW'(1);
            end
          end
        end
        EXEC: begin
          wen_q     <= 1'b0;
          state     <= RESP;
          rsp_valid <= 1'b1;
          rsp_addr  <= addr;
          rsp_last  <= 1'b1;
          if (op == OP_WR) begin
            rsp_data <= wdata;
            rsp_err  <= (addr == 5'd0);
          end else begin
            rsp_data <= rf_rdata;
            rsp_err  <= 1'b0;
`ifdef REG_DUMP_EN
            if (op == OP_DUMP) rsp_last <= (addr == 5'd31);
`endif
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          if (rsp_last) begin
            state    <= IDLE;
            halt_req <= 1'b0;
          end
`ifdef REG_DUMP_EN
          else begin
            // Mid-dump: keep the CPU halted; re-request only if it slipped out of halt.
            addr <= addr + 5'd1;
            if (halt_ack) begin
              state    <= EXEC;
              rf_raddr <= addr + 5'd1;
            end else begin
              state    <= REQ;
              tcnt     <= '0;
              ack_seen <= 1'b0;
            end
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_reg_debug_port.sv
// Self-checking bench for reg_debug_port: vector table for single commands,
// hand-written sequences for dump, halt loss and reset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module tb_reg_debug_port;
  localparam int DW = `DATA_WIDTH;
  localparam int TMO = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [4:0]    cmd_addr = 5'd0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic [4:0]    rsp_addr;
  logic          rsp_last;
  logic          rsp_err;
  logic          halt_req;
  logic          halt_ack = 1'b0;
  logic [4:0]    rf_raddr;
  logic [DW-1:0] rf_rdata;
  logic [4:0]    rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_wen;
  logic [1:0]    dbg_state;

  reg_debug_port #(.HALT_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_addr(rsp_addr), .rsp_last(rsp_last), .rsp_err(rsp_err),
    .halt_req(halt_req), .halt_ack(halt_ack),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wen(rf_wen), .dbg_state(dbg_state)
  );

  // ---- clock ----
  always #5 CLK = ~CLK;

  // ---- register file model ----
  logic [DW-1:0] rf [32];
  int            load_mode = 0;  // 1: table pattern, 2: dump pattern N*3
  int            wen_cnt = 0;
  int            wen_viol = 0;
  assign rf_rdata = rf[rf_raddr];

  always @(posedge CLK) begin
    if (load_mode == 1) begin
      for (int i = 0; i < 32; i++) rf[i] <= DW'(32'h1000 + i);
      rf[5] <= DW'(32'h1234);
    end else if (load_mode == 2) begin
      for (int i = 0; i < 32; i++) rf[i] <= DW'(i * 3);
    end else if (rf_wen) begin
      rf[rf_waddr] <= rf_wdata;
    end
    if (rf_wen) wen_cnt <= wen_cnt + 1;
    if (rf_wen && !halt_ack) wen_viol <= wen_viol + 1;
  end

  // ---- scoreboard ----
  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic load_rf(input int mode);
    load_mode = mode;
    step();
    load_mode = 0;
  endtask

  // ---- drivers ----
  task automatic send_cmd(input logic [1:0] op, input logic [4:0] a, input logic [DW-1:0] wd);
    chk("cmd_ready_idle", 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_addr  = a;
    cmd_wdata = wd;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input string name, output int lat);
    lat = 0;
    while (!rsp_valid && lat < 60) begin
      step();
      lat++;
    end
    if (!rsp_valid) chk({name, "_no_rsp"}, 64'd0, 64'd1);
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic check_reset_outs(input string name);
    chk({name, "_cmd_ready"}, 64'(cmd_ready), 64'd1);
    chk({name, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    chk({name, "_rsp_data"},  64'(rsp_data),  64'd0);
    chk({name, "_rsp_addr"},  64'(rsp_addr),  64'd0);
    chk({name, "_rsp_last"},  64'(rsp_last),  64'd0);
    chk({name, "_rsp_err"},   64'(rsp_err),   64'd0);
    chk({name, "_halt_req"},  64'(halt_req),  64'd0);
    chk({name, "_rf_wen"},    64'(rf_wen),    64'd0);
    chk({name, "_rf_raddr"},  64'(rf_raddr),  64'd0);
    chk({name, "_rf_waddr"},  64'(rf_waddr),  64'd0);
    chk({name, "_rf_wdata"},  64'(rf_wdata),  64'd0);
  endtask

  // ---- vector table ----
  typedef struct {
    string         name;
    logic [1:0]    op;
    logic [4:0]    addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] data;
    logic          err;
    logic          halt;
    int            lat;
    int            wens;
  } vec_t;

  vec_t vecs [12];
  int   nvec;

  initial begin
    int            lat;
    int            w0;
    logic [DW-1:0] e;

    nvec = 0;
    vecs[nvec++] = '{"rd5",      2'b00, 5'd5,  DW'(32'h0),        1'b1, DW'(32'h1234),     1'b0, 1'b1, 3,   0};
    vecs[nvec++] = '{"wr7",      2'b01, 5'd7,  DW'(32'hDEADBEEF), 1'b1, DW'(32'hDEADBEEF), 1'b0, 1'b1, 3,   1};
    vecs[nvec++] = '{"rd7",      2'b00, 5'd7,  DW'(32'h0),        1'b1, DW'(32'hDEADBEEF), 1'b0, 1'b1, 3,   0};
    vecs[nvec++] = '{"wr0",      2'b01, 5'd0,  DW'(32'h55),       1'b1, DW'(32'h55),       1'b1, 1'b1, 3,   0};
    vecs[nvec++] = '{"rd0",      2'b00, 5'd0,  DW'(32'h0),        1'b1, DW'(32'h1000),     1'b0, 1'b1, 3,   0};
    vecs[nvec++] = '{"rsvd",     2'b11, 5'd3,  DW'(32'h77),       1'b1, DW'(32'h0),        1'b1, 1'b0, 0,   0};
    vecs[nvec++] = '{"rd_tmo",   2'b00, 5'd9,  DW'(32'h0),        1'b0, DW'(32'h0),        1'b1, 1'b1, TMO, 0};
    vecs[nvec++] = '{"wr31",     2'b01, 5'd31, DW'(32'hA5A5A5A5), 1'b1, DW'(32'hA5A5A5A5), 1'b0, 1'b1, 3,   1};
    vecs[nvec++] = '{"rd31",     2'b00, 5'd31, DW'(32'h0),        1'b1, DW'(32'hA5A5A5A5), 1'b0, 1'b1, 3,   0};
    vecs[nvec++] = '{"wr_tmo",   2'b01, 5'd4,  DW'(32'h99),       1'b0, DW'(32'h0),        1'b1, 1'b1, TMO, 0};
`ifndef REG_DUMP_EN
    vecs[nvec++] = '{"dump_off", 2'b10, 5'd6,  DW'(32'h0),        1'b1, DW'(32'h0),        1'b1, 1'b0, 0,   0};
`endif

    // ---- reset ----
    repeat (3) step();
    check_reset_outs("rst_init");
    chk("dbg_state_idle", 64'(dbg_state), 64'd0);
    RST_N = 1'b1;
    load_rf(1);

    // ---- table ----
    for (int v = 0; v < nvec; v++) begin
      halt_ack = vecs[v].ack;
      w0 = wen_cnt;
      exp_q.push_back(vecs[v].data);
      send_cmd(vecs[v].op, vecs[v].addr, vecs[v].wdata);
      wait_rsp(vecs[v].name, lat);
      e = exp_q.pop_front();
      chk({vecs[v].name, "_lat"},  64'(lat),      64'(vecs[v].lat));
      chk({vecs[v].name, "_data"}, 64'(rsp_data), 64'(e));
      chk({vecs[v].name, "_err"},  64'(rsp_err),  64'(vecs[v].err));
      chk({vecs[v].name, "_last"}, 64'(rsp_last), 64'd1);
      chk({vecs[v].name, "_addr"}, 64'(rsp_addr), 64'(vecs[v].addr));
      chk({vecs[v].name, "_halt"}, 64'(halt_req), 64'(vecs[v].halt));
      repeat (2) step();
      chk({vecs[v].name, "_hold"}, 64'({rsp_valid, rsp_data}), 64'({1'b1, e}));
      handshake();
      chk({vecs[v].name, "_wens"},     64'(wen_cnt - w0), 64'(vecs[v].wens));
      chk({vecs[v].name, "_rsp_drop"}, 64'(rsp_valid),    64'd0);
      chk({vecs[v].name, "_halt_off"}, 64'(halt_req),     64'd0);
      chk({vecs[v].name, "_ready"},    64'(cmd_ready),    64'd1);
    end

`ifdef REG_DUMP_EN
    // ---- full dump with random back-pressure and one halt loss at addr 20 ----
    load_rf(2);
    halt_ack = 1'b1;
    for (int i = 0; i < 32; i++) exp_q.push_back(DW'(i * 3));
    send_cmd(2'b10, 5'd17, '0);
    for (int i = 0; i < 32; i++) begin
      wait_rsp("dump", lat);
      e = exp_q.pop_front();
      chk("dump_addr", 64'(rsp_addr), 64'(i));
      chk("dump_data", 64'(rsp_data), 64'(e));
      chk("dump_last", 64'(rsp_last), 64'(i == 31));
      chk("dump_err",  64'(rsp_err),  64'd0);
      chk("dump_halt", 64'(halt_req), 64'd1);
      repeat ($urandom_range(0, 3)) step();
      if (i == 20) halt_ack = 1'b0;
      handshake();
      if (i == 20) begin
        repeat (2) step();
        chk("dump_rereq_valid", 64'(rsp_valid), 64'd0);
        chk("dump_rereq_halt",  64'(halt_req),  64'd1);
        chk("dump_rereq_state", 64'(dbg_state), 64'd1);
        halt_ack = 1'b1;
      end
    end
    chk("dump_halt_end", 64'(halt_req), 64'd0);
    chk("dump_q_empty",  64'(exp_q.size()), 64'd0);

    // ---- reset while the dump sits at addr 12 ----
    send_cmd(2'b10, 5'd0, '0);
    for (int i = 0; i < 12; i++) begin
      wait_rsp("dump2", lat);
      handshake();
    end
    wait_rsp("dump2_12", lat);
    chk("dump2_addr12", 64'(rsp_addr), 64'd12);
    RST_N = 1'b0;
    step();
    check_reset_outs("rst_dump");
    RST_N = 1'b1;
    step();
    chk("rst_dump_ready", 64'(cmd_ready), 64'd1);
`else
    // ---- reset while a read waits for halt_ack ----
    halt_ack = 1'b0;
    send_cmd(2'b00, 5'd12, '0);
    step();
    chk("rst_mid_halt", 64'(halt_req), 64'd1);
    RST_N = 1'b0;
    step();
    check_reset_outs("rst_mid");
    RST_N = 1'b1;
    step();
    chk("rst_mid_ready", 64'(cmd_ready), 64'd1);
`endif

    // ---- post-reset read still works ----
    halt_ack = 1'b1;
    load_rf(1);
    send_cmd(2'b00, 5'd5, '0);
    wait_rsp("rd_after_rst", lat);
    chk("rd_after_rst_lat",  64'(lat),      64'd3);
    chk("rd_after_rst_data", 64'(rsp_data), 64'(DW'(32'h1234)));
    handshake();

    chk("wen_without_ack", 64'(wen_viol), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_debug_port.md
REG_DEBUG_PORT -- requirements
Module: reg_debug_port

Interface
REQ-001 SHALL have parameter HALT_TIMEOUT, default 255, max cycles waiting for halt_ack before error.
REQ-002 SHALL have ports: CLK  in  1  clock, all logic on rising edge.
REQ-003 SHALL have ports: RST_N  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports: cmd_valid in 1, cmd_ready out 1, cmd_op in 2 (00 read, 01 write, 10 dump, 11 reserved), cmd_addr in 5, cmd_wdata in `DATA_WIDTH.
REQ-005 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_data out `DATA_WIDTH, rsp_addr out 5, rsp_last out 1, rsp_err out 1.
REQ-006 SHALL have ports: halt_req out 1 (CPU stall request), halt_ack in 1 (CPU stalled, regfile ports owned by this block).
REQ-007 SHALL have ports: rf_raddr out 5, rf_rdata in `DATA_WIDTH (combinational read data), rf_waddr out 5, rf_wdata out `DATA_WIDTH, rf_wen out 1.

Function
REQ-008 SHALL implement FSM states IDLE, REQ, EXEC, RESP.
REQ-009 SHALL assert cmd_ready only in IDLE; command accepted on edge with cmd_valid && cmd_ready; op/addr/wdata latched.
REQ-010 SHALL go IDLE->REQ on accepting op 00, 01, or 10 (dump starts at addr 0, ignores cmd_addr).
REQ-011 SHALL assert halt_req from REQ entry until the final response handshake, continuously across a whole dump.
REQ-012 SHALL go REQ->EXEC on the cycle after halt_ack sampled 1; with halt_ack already high, rsp_valid rises exactly 3 cycles after accept.
REQ-013 SHALL count cycles in REQ; on reaching HALT_TIMEOUT without halt_ack go to RESP with rsp_err=1, rsp_data=0, rsp_last=1.
REQ-014 SHALL in EXEC drive rf_raddr=current addr and capture rf_rdata into rsp_data (read and dump), one cycle.
REQ-015 SHALL in EXEC for write pulse rf_wen=1 for exactly one cycle with rf_waddr/rf_wdata from command; rsp_data echoes wdata.
REQ-016 SHALL suppress rf_wen for write to addr 0 and respond rsp_err=1; rf_wen SHALL never be 1 outside EXEC or while halt_ack=0.
REQ-017 SHALL in RESP hold rsp_valid=1 and all rsp_* stable until rsp_ready sampled 1.
REQ-018 SHALL for read/write set rsp_last=1; on handshake drop halt_req, go IDLE.
REQ-019 SHALL for dump set rsp_addr=current addr, rsp_last=1 only at addr 31; on non-last handshake increment addr, return to EXEC (not REQ).
REQ-020 SHALL, if halt_ack falls during a dump, go RESP→REQ (not EXEC) on next handshake and re-wait with fresh timeout.
REQ-021 SHALL for op 11 go IDLE->RESP directly, rsp_err=1, rsp_last=1, halt_req never asserted.

Reset
REQ-022 SHALL on RST_N=0 at clock edge force IDLE, timeout counter 0, dump addr 0, mid-operation included.
REQ-023 SHALL reset outputs: cmd_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_last=0, rsp_err=0, halt_req=0, rf_wen=0, rf_raddr=0, rf_waddr=0, rf_wdata=0.

Configuration
REQ-024 SHALL compile dump support only when macro REG_DUMP_EN is defined.
REQ-025 SHALL without REG_DUMP_EN treat op 10 as op 11 (immediate error, no halt) and omit dump address counter logic.

Verification
REQ-026 Read: halt_ack=1, rf r5=0x1234, cmd op00 addr5 -> rsp_valid 3 cycles after accept, rsp_data=0x1234, err=0, last=1, halt_req then 0.
REQ-027 Write: op01 addr7 wdata 0xDEADBEEF -> one rf_wen pulse, waddr=7, rsp_data=0xDEADBEEF; op01 addr0 -> no rf_wen, rsp_err=1.
REQ-028 Timeout: HALT_TIMEOUT=4, halt_ack=0 -> rsp_err=1, rsp_data=0 after 4 REQ cycles, halt_req drops on handshake.
REQ-029 Dump (REG_DUMP_EN): rf rN=N*3, rsp_ready toggled randomly -> 32 responses, addr 0..31, data N*3, rsp_last only at 31, halt_req high throughout.
REQ-030 Reset/reserved: RST_N=0 mid-dump at addr 12 -> next cycle all outputs at reset values; op11 -> err response, halt_req stays 0.
